adder_issue: RTL
================

// Module: adder_issue
// PURPOSE
//  Issue buffer feeding the adder execution unit: the transmitting end of the adder_exeparam interface.
//  - Holds dispatched add/sub ops until both physical source operands are written back.
//  - Reads the operands from the register file and drives one registered packet per cycle.
//  - Sits between the dispatch stage and the adder, inside the backend execute cluster.
// PARAMETERS
//  DP   4                  buffer slots, 2..8
//  RB   `RB                rename bits; physical reg index width = 5+RB, PRF = 32<<RB regs
//  DW   `ADDER_EXEPARAM_DW exeparam width, must equal 2+(5+RB)+64+64+1
// PORTS
//  CLK                    in   1      clock, all state updates on rising edge
//  RST                    in   1      synchronous reset, active-high
//  flush                  in   1      pipeline flush, kills all buffered ops
//  dispatch_valid         in   1      dispatch offers an op this cycle
//  dispatch_ready         out  1      buffer can accept; transfer = valid & ready
//  dispatch_info          in   4+3*(5+RB)+64  {add,sub,is32,use_imm,rd0,rs1,rs2,imm[63:0]}
//  wbstate                in   32<<RB one bit per physical reg, 1 = value written back
//  rs1_addr / rs2_addr    out  5+RB   register file read indices (combinational)
//  rs1_data / rs2_data    in   64     register file read data, same cycle
//  adder_exeparam_vaild   out  1      packet valid to adder
//  adder_exeparam         out  DW     {rv64i_add,rv64i_sub,rd0,op1,op2,is32}, MSB first
// BEHAVIOUR
//  - Reset: all slot valid bits 0; adder_exeparam_vaild=0; adder_exeparam=0; dispatch_ready=1.
//  - Slots: each has valid, add, sub, is32, use_imm, rd0, rs1, rs2, imm.
//  - Allocation: an accepted op goes into the lowest-index free slot at the edge. dispatch_ready = !(all slots valid).
//  - Full buffer: ready is computed from registered state only, so a slot freed in the same cycle is not reusable that cycle.
//  - Operand ready: rsN arch bits [4:0]==0 reads as 0 and is always ready; otherwise wbstate[rsN] must be 1.
//  - use_imm=1: op2=imm and rs2 readiness is ignored.
//  - Select: lowest-index slot with valid and both operands ready.
//  - Issue: the selected slot drives rs1_addr/rs2_addr. At the edge, exeparam is registered, vaild=1 and the slot is cleared.
//  - Idle: with no ready slot, vaild=0 and exeparam holds its last value.
//  - Rate: at most one issue per cycle. The adder never back-pressures.
//  - Latency: op accepted at edge N is selectable in cycle N+1 and valid at the adder from edge N+2. This is the minimum.
//  - Same-cycle wake-up: a wbstate bit rising in cycle C makes its consumers selectable in cycle C itself.
//  - Operand forms: op1=rs1 data (or 0); op2=rs2 data, imm, or 0. sub/is32 pass through unchanged; the adder negates.
//  - Simultaneous dispatch and issue: both take effect. The issued slot is never the newly allocated one.
//  - Flush (highest priority): at the edge, all slots cleared and vaild=0. A dispatch in that cycle is dropped. No issue happens that cycle.
//  - RST during operation behaves as flush and also zeros adder_exeparam.
//  - Illegal dispatch: add==sub is never sent by dispatch. Behaviour is undefined; no check is made.
// CONFIGURATION
//  ADDER_ISSUE_PERF_EN defined:
//  - Adds out ports perf_issue_cnt[31:0] and perf_stall_cnt[31:0].
//  - perf_issue_cnt: +1 per issue.
//  - perf_stall_cnt: +1 per cycle with at least one valid slot and no issue.
//  - Both reset to 0, are not cleared by flush, and wrap at 2^32.
//  ADDER_ISSUE_PERF_EN undefined: no counters, no extra ports; all other behaviour identical.
// TESTING
//  T1 basic issue:
//   - Stimulus: wbstate all 1; dispatch add rd0=0x25 rs1=0x03 rs2=0x04 use_imm=0; regfile data 5 and 7.
//   - Response: two cycles later vaild=1 with {1,0,0x25,5,7,0}, then vaild=0.
//  T2 wait for wakeup:
//   - Stimulus: rs1=0x43 with wbstate[0x43]=0; raise wbstate[0x43] after 5 cycles.
//   - Response: vaild asserts at the next edge after the rise; op1 = data sampled in that cycle.
//  T3 full buffer:
//   - Stimulus: DP=4; dispatch 5 ops with no operands ready.
//   - Response: ready=0 after 4 accepts; the 5th is held until an issue frees a slot.
//  T4 x0 and immediate:
//   - Stimulus: rs1 arch=0, use_imm=1, imm=0xFFFF_FFFF_FFFF_FFFF, sub=1, is32=1.
//   - Response: packet op1=0, op2=imm, sub=1, is32=1 with no wbstate dependency.
//  T5 flush:
//   - Stimulus: 3 ops buffered; flush coincides with a ready slot and a dispatch.
//   - Response: next cycle vaild=0, all slots empty, ready=1, dropped op never issues.
//  T6 priority/perf:
//   - Stimulus: slots 0 and 2 become ready together.
//   - Response: slot 0 issues first, slot 2 the next cycle; with PERF_EN, issue count +2 and stall count unchanged.

Source files
------------

// File: rtl/adder_issue.sv
// adder_issue: issue buffer in front of the adder execution unit.
// Holds dispatched add/sub ops until both physical sources are written back,
// reads their operands from the register file and sends one registered
// packet per cycle to the adder.
// Optional build macro: ADDER_ISSUE_PERF_EN adds issue/stall counters.

`ifndef RB
`define RB 2
`endif
`ifndef ADDER_EXEPARAM_DW
`define ADDER_EXEPARAM_DW (2+(5+`RB)+64+64+1)
`endif

module adder_issue #(
  parameter int DP = 4,
  parameter int RB = `RB,
  parameter int DW = `ADDER_EXEPARAM_DW
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  output logic                        dispatch_ready,
  input  logic [4+3*(5+RB)+64-1:0]    dispatch_info,
  input  logic [(32<<RB)-1:0]         wbstate,
  output logic [5+RB-1:0]             rs1_addr,
  output logic [5+RB-1:0]             rs2_addr,
  input  logic [63:0]                 rs1_data,
  input  logic [63:0]                 rs2_data,
  output logic                        adder_exeparam_vaild,
  output logic [DW-1:0]               adder_exeparam
`ifdef ADDER_ISSUE_PERF_EN
  ,
  output logic [31:0]                 perf_issue_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  localparam int PW = 5 + RB;
  localparam int NR = 32 << RB;
  localparam int SW = (DP > 1) ? $clog2(DP) : 1;

  // Field order matches dispatch_info so the bus can be assigned directly.
  typedef struct packed {
    logic          add;
    logic          sub;
    logic          is32;
    logic          useImm;
    logic [PW-1:0] rd0;
    logic [PW-1:0] rs1;
    logic [PW-1:0] rs2;
    logic [63:0]   imm;
  } slot_t;

  logic [DP-1:0] r_valid;
  slot_t         r_slot [DP];
  logic          r_vaild;
  logic [DW-1:0] r_exeparam;

  logic [DP-1:0] w_ready;
  logic          w_selValid;
  logic [SW-1:0] w_selIdx;
  logic          w_freeValid;
  logic [SW-1:0] w_freeIdx;
  logic          w_accept;
  logic          w_issue;
  slot_t         w_sel;
  slot_t         w_new;
  logic [63:0]   w_op1;
  logic [63:0]   w_op2;
  logic [DW-1:0] w_packet;

  // Architectural register 0 (low five bits zero) is hardwired and never waits.
  function automatic logic srcReady(input logic [PW-1:0] idx, input logic [NR-1:0] wb);
    return (idx[4:0] == 5'd0) || wb[idx];
  endfunction

  assign w_new          = dispatch_info;
  assign dispatch_ready = ~&r_valid;
  assign w_accept       = dispatch_valid && dispatch_ready && !flush && w_freeValid;
  assign w_issue        = w_selValid && !flush;

  // Wake-up: a slot is ready when every source it needs is written back this cycle.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < DP; i++) begin
      w_ready[i] = r_valid[i]
                   && srcReady(r_slot[i].rs1, wbstate)
                   && (r_slot[i].useImm || srcReady(r_slot[i].rs2, wbstate));
    end
  end

  // Oldest-position priority: the lowest-index ready slot is selected.
  always_comb begin
    w_selValid = 1'b0;
    w_selIdx   = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_selValid = 1'b1;
        w_selIdx   = SW'(i);
      end
    end
  end

  // Allocation looks only at registered valids, so a slot issuing this cycle is not reused.
  always_comb begin
    w_freeValid = 1'b0;
    w_freeIdx   = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_freeValid = 1'b1;
        w_freeIdx   = SW'(i);
      end
    end
  end

  // Register file read and operand formation for the selected slot.
  always_comb begin
    w_sel    = r_slot[w_selIdx];
    rs1_addr = w_selValid ? w_sel.rs1 : '0;
    rs2_addr = w_selValid ? w_sel.rs2 : '0;
    w_op1    = (w_sel.rs1[4:0] == 5'd0) ? 64'd0 : rs1_data;
    if (w_sel.useImm) begin
      w_op2 = w_sel.imm;
    end else if (w_sel.rs2[4:0] == 5'd0) begin
      w_op2 = 64'd0;
    end else begin
      w_op2 = rs2_data;
    end
    w_packet = {w_sel.add, w_sel.sub, w_sel.rd0, w_op1, w_op2, w_sel.is32};
  end

  // Slot occupancy: flush and reset empty the buffer; otherwise issue frees and dispatch fills.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_valid <= '0;
    end else begin
      if (w_issue) begin
        r_valid[w_selIdx] <= 1'b0;
      end
      if (w_accept) begin
        r_valid[w_freeIdx] <= 1'b1;
      end
    end
  end

  // Slot payload is only meaningful while its valid bit is set, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_slot[w_freeIdx] <= w_new;
    end
  end

  // Output packet register: holds its last value when idle, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vaild    <= 1'b0;
      r_exeparam <= '0;
    end else if (flush) begin
      r_vaild    <= 1'b0;
    end else begin
      r_vaild <= w_selValid;
      if (w_selValid) begin
        r_exeparam <= w_packet;
      end
    end
  end

  assign adder_exeparam_vaild = r_vaild;
  assign adder_exeparam       = r_exeparam;

`ifdef ADDER_ISSUE_PERF_EN
  logic [31:0] r_issueCnt;
  logic [31:0] r_stallCnt;

  // Free-running counters survive flush so they span whole program runs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_issueCnt <= '0;
      r_stallCnt <= '0;
    end else begin
      if (w_issue) begin
        r_issueCnt <= r_issueCnt + 32'd1;
      end
      if ((|r_valid) && !w_issue) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = r_issueCnt;
  assign perf_stall_cnt = r_stallCnt;
`endif

endmodule
